// File: rtl/data_mem_ctrl.sv
// Byte-addressed, big-endian data memory behind a Req/Ready/Ack handshake.
// Supports byte and word accesses, configurable latency, and range/alignment errors.
module data_mem_ctrl #(
   parameter int    DATA_W      = 16,
   parameter int    ADDR_W      = 16,
   parameter int    DEPTH_BYTES = 128,
   parameter int    LATENCY     = 1,
   parameter string INIT_FILE   = "dataMemory.mem"
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Req,
   input  logic              WE,
   input  logic              Size,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] WriteData,
   output logic              Ready,
   output logic              Ack,
   output logic              Err,
   output logic [DATA_W-1:0] ReadData
);

   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
   localparam logic [ADDR_W:0]  DEPTH_END = (ADDR_W+1)'(DEPTH_BYTES);
   localparam logic [ADDR_W:0]  WORD_SPAN = (ADDR_W+1)'(BYTES);
   localparam logic [ADDR_W:0]  BYTE_SPAN = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;

   logic [7:0]        mem [DEPTH_BYTES];

   logic [ADDR_W-1:0] addr_p0;
   logic              we_p0;
   logic              size_p0;
   logic              err_p0;
   logic [DATA_W-1:0] wdata_p0;

   logic              accept;
   logic              req_err;
   logic [ADDR_W-1:0] cur_addr;
   logic              cur_we;
   logic              cur_size;
   logic [DATA_W-1:0] cur_wdata;
   logic              enter_resp;
   logic              resp_err;
   logic              commit;
   logic [DATA_W-1:0] rd_value;

   function automatic logic [IDX_W-1:0] byte_idx(input logic [ADDR_W-1:0] base, input int k);
      logic [ADDR_W-1:0] sum;
      sum = base + ADDR_W'(k);
      return sum[IDX_W-1:0];
   endfunction

   // End address is one bit wider than Address so a request near the top cannot wrap.
   function automatic logic access_err(input logic [ADDR_W-1:0] addr, input logic size);
      logic [ADDR_W:0] end_addr;
      logic            misaligned;
      end_addr   = {1'b0, addr} + (size ? WORD_SPAN : BYTE_SPAN);
      misaligned = size && ((addr % ADDR_W'(BYTES)) != '0);
      return (end_addr > DEPTH_END) || misaligned;
   endfunction

   assign accept  = (state == IDLE) && Req;
   assign req_err = access_err(Address, Size);

   // With LATENCY=1 the response edge is the accept edge, so live inputs feed the access.
   always_comb begin
      cur_addr  = addr_p0;
      cur_we    = we_p0;
      cur_size  = size_p0;
      cur_wdata = wdata_p0;
      if (state == IDLE) begin
         cur_addr  = Address;
         cur_we    = WE;
         cur_size  = Size;
         cur_wdata = WriteData;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (Req) begin
               state_next = (req_err || (LATENCY == 1)) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == CNT_LAST) begin
               state_next = RESP;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enter_resp = (state_next == RESP) && (state != RESP);
   assign resp_err   = (state == IDLE) && req_err;
   assign commit     = enter_resp && !resp_err && cur_we;

   always_comb begin
      rd_value = '0;
      if (cur_size) begin
         for (int k = 0; k < BYTES; k++) begin
            rd_value[DATA_W-1-8*k -: 8] = mem[byte_idx(cur_addr, k)];
         end
      end else begin
         rd_value[7:0] = mem[byte_idx(cur_addr, 0)];
      end
   end

   // Control state and the response register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         ReadData <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (enter_resp) begin
            if (resp_err) begin
               ReadData <= '0;
            end else if (!cur_we) begin
               ReadData <= rd_value;
            end
         end
      end
   end

   // Request capture stage (p0): held for the WAIT cycles
   always_ff @(posedge Clock) begin
      if (accept) begin
         addr_p0  <= Address;
         we_p0    <= WE;
         size_p0  <= Size;
         wdata_p0 <= WriteData;
         err_p0   <= req_err;
      end
   end

   // Storage write port: commits only on the edge entering RESP, so a reset in WAIT drops it
   always_ff @(posedge Clock) begin
      if (commit) begin
         if (cur_size) begin
            for (int k = 0; k < BYTES; k++) begin
               mem[byte_idx(cur_addr, k)] <= cur_wdata[DATA_W-1-8*k -: 8];
            end
         end else begin
            mem[byte_idx(cur_addr, 0)] <= cur_wdata[7:0];
         end
      end
   end

   assign Ready = (state == IDLE);
   assign Ack   = (state == RESP);
   assign Err   = (state == RESP) && err_p0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (LATENCY 1, 3, 4) checked against a
// byte-array reference model with directed and randomized transactions.
module tb_data_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req   [3];
   logic        we    [3];
   logic        size  [3];
   logic [15:0] addr  [3];
   logic [15:0] wdata [3];
   logic        ready [3];
   logic        ack   [3];
   logic        err   [3];
   logic [15:0] rdata [3];

   logic [7:0]  mem_m   [3][128];
   logic [15:0] last_rd [3];
   int          lat     [3] = '{1, 3, 4};

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(128), .LATENCY(1), .INIT_FILE("")) u_l1 (
      .Clock(clk), .Reset(rst), .Req(req[0]), .WE(we[0]), .Size(size[0]), .Address(addr[0]),
      .WriteData(wdata[0]), .Ready(ready[0]), .Ack(ack[0]), .Err(err[0]), .ReadData(rdata[0]));

   data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(128), .LATENCY(3), .INIT_FILE("")) u_l3 (
      .Clock(clk), .Reset(rst), .Req(req[1]), .WE(we[1]), .Size(size[1]), .Address(addr[1]),
      .WriteData(wdata[1]), .Ready(ready[1]), .Ack(ack[1]), .Err(err[1]), .ReadData(rdata[1]));

   data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(128), .LATENCY(4), .INIT_FILE("")) u_l4 (
      .Clock(clk), .Reset(rst), .Req(req[2]), .WE(we[2]), .Size(size[2]), .Address(addr[2]),
      .WriteData(wdata[2]), .Ready(ready[2]), .Ack(ack[2]), .Err(err[2]), .ReadData(rdata[2]));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction on instance i; inputs are scrambled after accept to prove latching.
   task automatic txn(input logic [1:0] i, input logic w, input logic sz, input logic [15:0] a,
                      input logic [15:0] wd, output logic [15:0] rd);
      logic       bad;
      int         e;
      int         end_b;
      logic [6:0] ix;
      logic [6:0] ix1;
      logic [15:0] exp;
      end_b = int'(a) + (sz ? 2 : 1);
      bad   = (end_b > 128) || (sz && a[0]);
      e     = bad ? 1 : lat[i];
      ix    = a[6:0];
      ix1   = ix + 7'd1;
      @(negedge clk);
      check($sformatf("ready_idle i%0d a%0d", i, a), 16'(ready[i]), 16'd1);
      req[i] = 1'b1; we[i] = w; size[i] = sz; addr[i] = a; wdata[i] = wd;
      for (int k = 1; k <= e; k++) begin
         @(negedge clk);
         if (k == 1) begin
            we[i]    = 1'($urandom);
            size[i]  = 1'($urandom);
            addr[i]  = 16'($urandom);
            wdata[i] = 16'($urandom);
         end
         check($sformatf("ready_busy i%0d k%0d", i, k), 16'(ready[i]), 16'd0);
         check($sformatf("ack i%0d k%0d", i, k), 16'(ack[i]), 16'(k == e));
         req[i] = (k < e) ? 1'($urandom) : 1'b0;
      end
      if (bad) begin
         exp = 16'h0000;
      end else if (!w) begin
         exp = sz ? {mem_m[i][ix], mem_m[i][ix1]} : {8'h00, mem_m[i][ix]};
      end else begin
         exp = last_rd[i];
         if (sz) begin
            mem_m[i][ix]  = wd[15:8];
            mem_m[i][ix1] = wd[7:0];
         end else begin
            mem_m[i][ix] = wd[7:0];
         end
      end
      check($sformatf("err i%0d a%0d", i, a), 16'(err[i]), 16'(bad));
      check($sformatf("rdata i%0d a%0d", i, a), rdata[i], exp);
      last_rd[i] = exp;
      rd = rdata[i];
      @(negedge clk);
      check($sformatf("ready_back i%0d", i), 16'(ready[i]), 16'd1);
      check($sformatf("ack_drop i%0d", i), 16'(ack[i]), 16'd0);
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] old_word;
      logic [1:0]  ii;
      logic [15:0] ra;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; size[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
         last_rd[i] = '0;
      end

      // Asynchronous reset asserted mid-cycle
      #12 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ack i%0d", i), 16'(ack[i]), 16'd0);
         check($sformatf("rst_err i%0d", i), 16'(err[i]), 16'd0);
         check($sformatf("rst_rdata i%0d", i), rdata[i], 16'h0000);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_ready i%0d", i), 16'(ready[i]), 16'd1);
      end

      // Fill every byte of every instance so the model knows all contents
      for (int i = 0; i < 3; i++) begin
         for (int a = 0; a < 128; a += 2) begin
            txn(2'(i), 1'b1, 1'b1, 16'(a), 16'($urandom), rd);
         end
      end

      // Word/byte big-endian behaviour on the single-cycle instance
      txn(2'd0, 1'b1, 1'b1, 16'd4, 16'hA55A, rd);
      txn(2'd0, 1'b0, 1'b1, 16'd4, 16'h0000, rd);
      check("word_rd_4", rd, 16'hA55A);
      txn(2'd0, 1'b0, 1'b0, 16'd4, 16'h0000, rd);
      check("byte_rd_4", rd, 16'h00A5);
      txn(2'd0, 1'b0, 1'b0, 16'd5, 16'h0000, rd);
      check("byte_rd_5", rd, 16'h005A);
      txn(2'd0, 1'b1, 1'b0, 16'd5, 16'hFF3C, rd);
      txn(2'd0, 1'b0, 1'b1, 16'd4, 16'h0000, rd);
      check("word_rd_4_after_byte", rd, 16'hA53C);
      txn(2'd0, 1'b0, 1'b0, 16'd4, 16'h0000, rd);
      check("byte_rd_4_zext", rd, 16'h00A5);

      // Error cases and edge-of-memory legal accesses
      txn(2'd0, 1'b0, 1'b1, 16'd3, 16'h0000, rd);
      check("err_misaligned_rdata", rd, 16'h0000);
      txn(2'd0, 1'b1, 1'b1, 16'd127, 16'hBEEF, rd);
      txn(2'd0, 1'b0, 1'b0, 16'd127, 16'h0000, rd);
      txn(2'd0, 1'b1, 1'b0, 16'd127, 16'h0077, rd);
      txn(2'd0, 1'b0, 1'b0, 16'd127, 16'h0000, rd);
      check("byte_127_legal", rd, 16'h0077);
      txn(2'd0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, rd);
      txn(2'd0, 1'b0, 1'b1, 16'd126, 16'h0000, rd);
      txn(2'd1, 1'b1, 1'b1, 16'd128, 16'h1111, rd);

      // Multi-cycle latency with Req toggled during the wait
      txn(2'd1, 1'b1, 1'b1, 16'd10, 16'hC0DE, rd);
      txn(2'd1, 1'b0, 1'b1, 16'd10, 16'h0000, rd);
      check("l3_word_rd_10", rd, 16'hC0DE);

      // Reset two cycles into a LATENCY=4 write: the write must be dropped
      old_word = {mem_m[2][8], mem_m[2][9]};
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; size[2] = 1'b1; addr[2] = 16'd8; wdata[2] = ~old_word;
      @(negedge clk);
      req[2] = 1'b0;
      check("abort_busy1", 16'(ready[2]), 16'd0);
      @(negedge clk);
      check("abort_busy2", 16'(ack[2]), 16'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_ack", 16'(ack[2]), 16'd0);
      check("abort_rdata", rdata[2], 16'h0000);
      for (int i = 0; i < 3; i++) last_rd[i] = '0;
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("abort_no_ack k%0d", k), 16'(ack[2]), 16'd0);
         check($sformatf("abort_ready k%0d", k), 16'(ready[2]), 16'd1);
      end
      txn(2'd2, 1'b0, 1'b1, 16'd8, 16'h0000, rd);
      check("abort_old_contents", rd, old_word);

      // Randomized traffic across all three instances
      for (int n = 0; n < 60; n++) begin
         ii = 2'($urandom_range(0, 2));
         ra = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFF00, 16'hFFFF))
                                          : 16'($urandom_range(0, 131));
         txn(ii, 1'($urandom), 1'($urandom), ra, 16'($urandom), rd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
